// File: rtl/snax_mem_to_axi.sv
// Bridges a simple request/grant memory port onto an AXI4 master, one single-beat
// transaction in flight at a time; responses come back as a one-cycle pulse.
module snax_mem_to_axi #(
    parameter int unsigned AddrWidth = 48,
    parameter int unsigned DataWidth = 64,
    localparam int unsigned StrbWidth = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic                 mem_req_i,
    output logic                 mem_gnt_o,
    input  logic [AddrWidth-1:0] mem_addr_i,
    input  logic                 mem_we_i,
    input  logic [DataWidth-1:0] mem_wdata_i,
    input  logic [StrbWidth-1:0] mem_strb_i,
    output logic                 mem_rvalid_o,
    output logic [DataWidth-1:0] mem_rdata_o,
    output logic                 mem_err_o,

    output logic                 m_axi_awvalid,
    input  logic                 m_axi_awready,
    output logic [AddrWidth-1:0] m_axi_awaddr,

    output logic                 m_axi_wvalid,
    input  logic                 m_axi_wready,
    output logic [DataWidth-1:0] m_axi_wdata,
    output logic [StrbWidth-1:0] m_axi_wstrb,

    input  logic                 m_axi_bvalid,
    output logic                 m_axi_bready,
    input  logic [1:0]           m_axi_bresp,

    output logic                 m_axi_arvalid,
    input  logic                 m_axi_arready,
    output logic [AddrWidth-1:0] m_axi_araddr,

    input  logic                 m_axi_rvalid,
    output logic                 m_axi_rready,
    input  logic [DataWidth-1:0] m_axi_rdata,
    input  logic [1:0]           m_axi_rresp
);

    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        BWAIT,
        READ,
        RWAIT
    } state_e;

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic [StrbWidth-1:0] strb_q, strb_d;
    logic                 aw_done_q, aw_done_d;
    logic                 w_done_q, w_done_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [DataWidth-1:0] rsp_data_q, rsp_data_d;
    logic                 rsp_err_q, rsp_err_d;

    // EXOKAY is a success; only SLVERR and DECERR are reported upstream.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RespSlvErr) || (resp == RespDecErr);
    endfunction

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        strb_d        = strb_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        rsp_valid_d   = 1'b0;
        rsp_data_d    = rsp_data_q;
        rsp_err_d     = rsp_err_q;
        mem_gnt_o     = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;

        unique case (state_q)
            IDLE: begin
                mem_gnt_o = mem_req_i & rst_ni;
                if (mem_gnt_o) begin
                    addr_d    = mem_addr_i;
                    wdata_d   = mem_wdata_i;
                    strb_d    = mem_strb_i;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = mem_we_i ? WRITE : READ;
                end
            end

            WRITE: begin
                // AW and W retire independently; either order or both at once is fine.
                m_axi_awvalid = ~aw_done_q;
                m_axi_wvalid  = ~w_done_q;
                aw_done_d     = aw_done_q | (m_axi_awvalid & m_axi_awready);
                w_done_d      = w_done_q  | (m_axi_wvalid  & m_axi_wready);
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = BWAIT;
                end
            end

            BWAIT: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_err_d   = resp_is_err(m_axi_bresp);
                    state_d     = IDLE;
                end
            end

            READ: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    state_d = RWAIT;
                end
            end

            RWAIT: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = m_axi_rdata;
                    rsp_err_d   = resp_is_err(m_axi_rresp);
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            strb_q      <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            strb_q      <= strb_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign m_axi_awaddr = addr_q;
    assign m_axi_araddr = addr_q;
    assign m_axi_wdata  = wdata_q;
    assign m_axi_wstrb  = strb_q;

    assign mem_rvalid_o = rsp_valid_q;
    assign mem_rdata_o  = rsp_data_q;
    assign mem_err_o    = rsp_err_q;

endmodule

// File: tb/tb_snax_mem_to_axi.sv
// Directed and randomized bench for snax_mem_to_axi: an AXI slave model with
// per-channel ready/valid delays plus a transaction-level response and latency model.
module tb_snax_mem_to_axi;

    localparam int AW = 48;
    localparam int DW = 64;
    localparam int SW = DW / 8;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          err;
    } rsp_t;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          mem_req_i, mem_gnt_o, mem_we_i, mem_rvalid_o, mem_err_o;
    logic [AW-1:0] mem_addr_i;
    logic [DW-1:0] mem_wdata_i, mem_rdata_o;
    logic [SW-1:0] mem_strb_i;
    logic          m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic          m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic          m_axi_rvalid, m_axi_rready;
    logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
    logic [DW-1:0] m_axi_wdata, m_axi_rdata;
    logic [SW-1:0] m_axi_wstrb;
    logic [1:0]    m_axi_bresp, m_axi_rresp;

    snax_mem_to_axi #(.AddrWidth(AW), .DataWidth(DW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .mem_req_i(mem_req_i), .mem_gnt_o(mem_gnt_o), .mem_addr_i(mem_addr_i),
        .mem_we_i(mem_we_i), .mem_wdata_i(mem_wdata_i), .mem_strb_i(mem_strb_i),
        .mem_rvalid_o(mem_rvalid_o), .mem_rdata_o(mem_rdata_o), .mem_err_o(mem_err_o),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Slave configuration, set by the stimulus between transactions.
    int aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
    int n_aw = 0, n_w = 0, n_ar = 0, n_b = 0, n_r = 0, n_gnt = 0, n_resp = 0;
    bit b_hs_flag = 0, r_hs_flag = 0, flush_req = 0;

    logic [AW-1:0] exp_aw[$], exp_ar[$];
    logic [DW-1:0] exp_wd[$], rdata_sq[$];
    logic [SW-1:0] exp_ws[$];
    logic [1:0]    bresp_sq[$], rresp_sq[$];
    rsp_t          exp_rsp[$];

    logic [DW-1:0] last_rdata = '0;
    logic          last_err = 1'b0;
    rsp_t          mon_rsp;
    logic          prev_awvalid = 0, prev_awready = 0, prev_aw_hs = 0;
    logic          prev_wvalid = 0, prev_wready = 0, prev_w_hs = 0;
    logic          prev_arvalid = 0, prev_arready = 0, prev_ar_hs = 0;
    logic [AW-1:0] prev_awaddr = '0, prev_araddr = '0;
    logic [DW-1:0] prev_wdata = '0;
    logic [SW-1:0] prev_wstrb = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Slave driver (at negedge) and pre-edge monitor (negedge + 2) in one process.
    initial begin : slave_monitor
        m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        m_axi_bvalid = 0; m_axi_bresp = '0; m_axi_rvalid = 0; m_axi_rresp = '0; m_axi_rdata = '0;
        forever begin
            @(negedge clk_i);
            if (flush_req) begin
                m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
                m_axi_bvalid = 0; m_axi_rvalid = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
                n_aw = 0; n_w = 0; n_ar = 0; n_b = 0; n_r = 0; n_gnt = 0; n_resp = 0;
                b_hs_flag = 0; r_hs_flag = 0;
                exp_aw.delete(); exp_ar.delete(); exp_wd.delete(); exp_ws.delete();
                rdata_sq.delete(); bresp_sq.delete(); rresp_sq.delete(); exp_rsp.delete();
                last_rdata = '0; last_err = 1'b0;
                prev_awvalid = 0; prev_awready = 0; prev_aw_hs = 0;
                prev_wvalid = 0; prev_wready = 0; prev_w_hs = 0;
                prev_arvalid = 0; prev_arready = 0; prev_ar_hs = 0;
                flush_req = 0;
            end
            if (b_hs_flag) begin m_axi_bvalid = 0; b_hs_flag = 0; b_cnt = 0; end
            if (r_hs_flag) begin m_axi_rvalid = 0; r_hs_flag = 0; r_cnt = 0; end

            if (m_axi_awvalid) begin
                if (aw_cnt >= aw_delay) m_axi_awready = 1;
                else begin m_axi_awready = 0; aw_cnt++; end
            end else begin m_axi_awready = 0; aw_cnt = 0; end
            if (m_axi_wvalid) begin
                if (w_cnt >= w_delay) m_axi_wready = 1;
                else begin m_axi_wready = 0; w_cnt++; end
            end else begin m_axi_wready = 0; w_cnt = 0; end
            if (m_axi_arvalid) begin
                if (ar_cnt >= ar_delay) m_axi_arready = 1;
                else begin m_axi_arready = 0; ar_cnt++; end
            end else begin m_axi_arready = 0; ar_cnt = 0; end

            if (!m_axi_bvalid && ((n_aw < n_w ? n_aw : n_w) > n_b) && bresp_sq.size() != 0) begin
                if (b_cnt >= b_delay) begin m_axi_bvalid = 1; m_axi_bresp = bresp_sq.pop_front(); end
                else b_cnt++;
            end
            if (!m_axi_rvalid && (n_ar > n_r) && rresp_sq.size() != 0) begin
                if (r_cnt >= r_delay) begin
                    m_axi_rvalid = 1; m_axi_rresp = rresp_sq.pop_front(); m_axi_rdata = rdata_sq.pop_front();
                end else r_cnt++;
            end

            #2;
            if (prev_awvalid && !prev_awready) begin
                chk("aw_hold", 64'(m_axi_awvalid), 64'd1);
                chk("aw_addr_stable", 64'(m_axi_awaddr), 64'(prev_awaddr));
            end
            if (prev_wvalid && !prev_wready) begin
                chk("w_hold", 64'(m_axi_wvalid), 64'd1);
                chk("w_data_stable", 64'(m_axi_wdata), 64'(prev_wdata));
                chk("w_strb_stable", 64'(m_axi_wstrb), 64'(prev_wstrb));
            end
            if (prev_arvalid && !prev_arready) begin
                chk("ar_hold", 64'(m_axi_arvalid), 64'd1);
                chk("ar_addr_stable", 64'(m_axi_araddr), 64'(prev_araddr));
            end
            if (prev_aw_hs) chk("aw_drop", 64'(m_axi_awvalid), 64'd0);
            if (prev_w_hs)  chk("w_drop", 64'(m_axi_wvalid), 64'd0);
            if (prev_ar_hs) chk("ar_drop", 64'(m_axi_arvalid), 64'd0);

            if (m_axi_awvalid && m_axi_awready) begin
                n_aw++;
                chk("aw_expected", 64'(exp_aw.size() != 0), 64'd1);
                if (exp_aw.size() != 0) chk("awaddr", 64'(m_axi_awaddr), 64'(exp_aw.pop_front()));
            end
            if (m_axi_wvalid && m_axi_wready) begin
                n_w++;
                chk("w_expected", 64'(exp_wd.size() != 0), 64'd1);
                if (exp_wd.size() != 0) begin
                    chk("wdata", 64'(m_axi_wdata), 64'(exp_wd.pop_front()));
                    chk("wstrb", 64'(m_axi_wstrb), 64'(exp_ws.pop_front()));
                end
            end
            if (m_axi_arvalid && m_axi_arready) begin
                n_ar++;
                chk("ar_expected", 64'(exp_ar.size() != 0), 64'd1);
                if (exp_ar.size() != 0) chk("araddr", 64'(m_axi_araddr), 64'(exp_ar.pop_front()));
            end
            if (m_axi_bvalid && m_axi_bready) begin n_b++; b_hs_flag = 1; end
            if (m_axi_rvalid && m_axi_rready) begin n_r++; r_hs_flag = 1; end

            if (mem_rvalid_o) begin
                chk("rsp_expected", 64'(exp_rsp.size() != 0), 64'd1);
                if (exp_rsp.size() != 0) begin
                    mon_rsp = exp_rsp.pop_front();
                    chk("rsp_rdata", 64'(mem_rdata_o), 64'(mon_rsp.data));
                    chk("rsp_err", 64'(mem_err_o), 64'(mon_rsp.err));
                end
                last_rdata = mem_rdata_o;
                last_err   = mem_err_o;
                n_resp++;
            end else begin
                chk("rdata_hold", 64'(mem_rdata_o), 64'(last_rdata));
                chk("err_hold", 64'(mem_err_o), 64'(last_err));
            end

            if (mem_req_i && (m_axi_awvalid || m_axi_wvalid || m_axi_arvalid || m_axi_bready || m_axi_rready))
                chk("gnt_while_busy", 64'(mem_gnt_o), 64'd0);
            if (mem_gnt_o) begin
                chk("gnt_needs_req", 64'(mem_req_i), 64'd1);
                chk("gnt_single_outstanding", 64'(n_resp), 64'(n_gnt));
                n_gnt++;
            end

            prev_awvalid = m_axi_awvalid; prev_awready = m_axi_awready; prev_awaddr = m_axi_awaddr;
            prev_aw_hs   = m_axi_awvalid && m_axi_awready;
            prev_wvalid  = m_axi_wvalid;  prev_wready  = m_axi_wready;
            prev_wdata   = m_axi_wdata;   prev_wstrb   = m_axi_wstrb;
            prev_w_hs    = m_axi_wvalid && m_axi_wready;
            prev_arvalid = m_axi_arvalid; prev_arready = m_axi_arready; prev_araddr = m_axi_araddr;
            prev_ar_hs   = m_axi_arvalid && m_axi_arready;
        end
    end

    // Reference model: what the slave will return and what the memory side must see.
    task automatic issue(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input logic [SW-1:0] st, input logic [DW-1:0] rd, input logic [1:0] resp);
        rsp_t e;
        if (we) begin
            exp_aw.push_back(addr); exp_wd.push_back(wd); exp_ws.push_back(st);
            bresp_sq.push_back(resp);
            e.data = '0;
        end else begin
            exp_ar.push_back(addr); rdata_sq.push_back(rd); rresp_sq.push_back(resp);
            e.data = rd;
        end
        e.err = (resp == SLVERR) || (resp == DECERR);
        exp_rsp.push_back(e);
    endtask

    task automatic run_txn(input string tag, input bit we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input logic [SW-1:0] st,
                           input logic [DW-1:0] rd, input logic [1:0] resp, input int exp_lat);
        int g0, r0, a0, w0, ar0, b0, rr0, lat;
        g0 = n_gnt; r0 = n_resp; a0 = n_aw; w0 = n_w; ar0 = n_ar; b0 = n_b; rr0 = n_r;
        issue(we, addr, wd, st, rd, resp);
        @(negedge clk_i);
        mem_req_i = 1; mem_we_i = we; mem_addr_i = addr; mem_wdata_i = wd; mem_strb_i = st;
        for (int i = 0; i < 100; i++) begin
            #3;
            if (n_gnt != g0) break;
            @(negedge clk_i);
        end
        chk({tag, "_grant"}, 64'(n_gnt - g0), 64'd1);
        @(negedge clk_i);
        mem_req_i = 0;
        lat = 1;
        #3;
        chk({tag, "_valids_cycle1"}, 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}),
            we ? 64'd6 : 64'd1);
        for (int i = 0; i < 200; i++) begin
            if (n_resp != r0) break;
            @(negedge clk_i);
            lat++;
            #3;
        end
        chk({tag, "_response"}, 64'(n_resp - r0), 64'd1);
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_aw_count"}, 64'(n_aw - a0), 64'(we));
        chk({tag, "_w_count"}, 64'(n_w - w0), 64'(we));
        chk({tag, "_b_count"}, 64'(n_b - b0), 64'(we));
        chk({tag, "_ar_count"}, 64'(n_ar - ar0), 64'(!we));
        chk({tag, "_r_count"}, 64'(n_r - rr0), 64'(!we));
    endtask

    task automatic set_delays(input int aw, input int w, input int b, input int ar, input int r);
        aw_delay = aw; w_delay = w; b_delay = b; ar_delay = ar; r_delay = r;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [63:0]   r64;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd, rd;
        logic [SW-1:0] st;
        logic [1:0]    resp;
        bit            we;
        int            g0, r0, ar0, cyc, ad, wdl, bd, ard, rdl;

        rst_ni = 1; mem_req_i = 0; mem_we_i = 0; mem_addr_i = '0; mem_wdata_i = '0; mem_strb_i = '0;
        #1 rst_ni = 0;
        mem_req_i = 1;
        #2;
        chk("reset_ctrl_outputs", 64'({mem_gnt_o, mem_rvalid_o, mem_err_o, m_axi_awvalid, m_axi_wvalid,
                                       m_axi_bready, m_axi_arvalid, m_axi_rready}), 64'd0);
        chk("reset_rdata", 64'(mem_rdata_o), 64'd0);
        chk("reset_payload", 64'(m_axi_awaddr) | 64'(m_axi_wdata) | 64'(m_axi_wstrb), 64'd0);
        mem_req_i = 0;
        repeat (2) @(negedge clk_i);
        #3 rst_ni = 1;

        // Zero-wait read with a known pattern.
        set_delays(0, 0, 0, 0, 0);
        run_txn("rd_basic", 0, 48'h0000_8000_0008, '0, '0, 64'hDEAD_BEEF_0123_4567, OKAY, 3);
        // AW accepted three cycles before W.
        set_delays(0, 3, 0, 0, 0);
        run_txn("wr_aw_first", 1, 48'h0000_8000_0010, 64'h1122_3344_5566_7788, 8'h0F, '0, OKAY, 6);
        // W before AW, then simultaneous with and without wait.
        set_delays(2, 0, 0, 0, 0);
        run_txn("wr_w_first", 1, 48'h0000_8000_0020, 64'hA5A5_0000_FFFF_1234, 8'hF0, '0, OKAY, 5);
        set_delays(0, 0, 0, 0, 0);
        run_txn("wr_simul", 1, 48'h0000_8000_0028, 64'h0BAD_CAFE_0000_0001, 8'hFF, '0, EXOKAY, 3);
        set_delays(1, 1, 2, 0, 0);
        run_txn("wr_simul_wait", 1, 48'h0000_8000_0030, 64'h7777_8888_9999_AAAA, 8'h3C, '0, SLVERR, 6);
        // Error mapping on reads.
        set_delays(0, 0, 0, 1, 1);
        run_txn("rd_decerr", 0, 48'h0000_9000_0000, '0, '0, 64'h0123_4567_89AB_CDEF, DECERR, 5);
        run_txn("rd_okay", 0, 48'h0000_9000_0008, '0, '0, 64'hFEDC_BA98_7654_3210, OKAY, 5);
        run_txn("rd_exokay", 0, 48'h0000_9000_0010, '0, '0, 64'h5555_AAAA_5555_AAAA, EXOKAY, 5);

        // Randomized mix; latency from the handshake-delay model.
        for (int i = 0; i < 20; i++) begin
            we = 1'($urandom_range(0, 1));
            r64 = {$urandom(), $urandom()}; addr = r64[AW-1:0];
            wd = {$urandom(), $urandom()};
            rd = {$urandom(), $urandom()};
            st = SW'($urandom());
            resp = 2'($urandom_range(0, 3));
            ad = int'($urandom_range(0, 3)); wdl = int'($urandom_range(0, 3));
            bd = int'($urandom_range(0, 3)); ard = int'($urandom_range(0, 3));
            rdl = int'($urandom_range(0, 3));
            set_delays(ad, wdl, bd, ard, rdl);
            run_txn("rand", we, addr, wd, st, rd, resp,
                    we ? 3 + (ad > wdl ? ad : wdl) + bd : 3 + ard + rdl);
        end

        // Back-to-back reads with the request held high.
        set_delays(0, 0, 0, 0, 0);
        g0 = n_gnt; r0 = n_resp; ar0 = n_ar;
        for (int i = 0; i < 6; i++) begin
            rd = {$urandom(), $urandom()};
            issue(0, 48'h0000_A000_0040, '0, '0, rd, (i == 2) ? SLVERR : OKAY);
        end
        @(negedge clk_i);
        mem_req_i = 1; mem_we_i = 0; mem_addr_i = 48'h0000_A000_0040;
        cyc = 0;
        for (int i = 0; i < 200; i++) begin
            #3;
            if (n_gnt - g0 >= 6) break;
            @(negedge clk_i);
            cyc++;
        end
        @(negedge clk_i);
        mem_req_i = 0;
        chk("b2b_grants", 64'(n_gnt - g0), 64'd6);
        chk("b2b_spacing", 64'(cyc), 64'd15);
        for (int i = 0; i < 50; i++) begin
            #3;
            if (n_resp - r0 >= 6) break;
            @(negedge clk_i);
        end
        repeat (3) @(negedge clk_i);
        chk("b2b_responses", 64'(n_resp - r0), 64'd6);
        chk("b2b_ar_count", 64'(n_ar - ar0), 64'd6);

        // Reset while waiting for B, then a normal read.
        set_delays(0, 0, 20, 0, 0);
        g0 = n_gnt;
        issue(1, 48'h0000_B000_0000, 64'hCAFE_F00D_1234_5678, 8'hAA, '0, OKAY);
        @(negedge clk_i);
        mem_req_i = 1; mem_we_i = 1; mem_addr_i = 48'h0000_B000_0000;
        mem_wdata_i = 64'hCAFE_F00D_1234_5678; mem_strb_i = 8'hAA;
        for (int i = 0; i < 50; i++) begin
            #3;
            if (n_gnt != g0) break;
            @(negedge clk_i);
        end
        @(negedge clk_i);
        mem_req_i = 0;
        for (int i = 0; i < 50; i++) begin
            #3;
            if (m_axi_bready) break;
            @(negedge clk_i);
        end
        chk("rst_reached_bwait", 64'(m_axi_bready), 64'd1);
        @(negedge clk_i);
        #3 rst_ni = 0;
        mem_req_i = 1;
        #1;
        chk("rst_async_ctrl", 64'({mem_gnt_o, mem_rvalid_o, mem_err_o, m_axi_awvalid, m_axi_wvalid,
                                   m_axi_bready, m_axi_arvalid, m_axi_rready}), 64'd0);
        chk("rst_async_rdata", 64'(mem_rdata_o), 64'd0);
        chk("rst_async_payload", 64'(m_axi_awaddr) | 64'(m_axi_wdata) | 64'(m_axi_wstrb), 64'd0);
        flush_req = 1;
        mem_req_i = 0;
        repeat (2) @(negedge clk_i);
        #3 rst_ni = 1;
        set_delays(0, 0, 0, 0, 0);
        run_txn("rd_after_rst", 0, 48'h0000_C000_0018, '0, '0, 64'h0F0F_F0F0_1357_9BDF, OKAY, 3);
        repeat (3) @(negedge clk_i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/snax_mem_to_axi.md
SNAX_MEM_TO_AXI -- requirements
Module: snax_mem_to_axi

Interface
REQ-001 SHALL have parameter AddrWidth, default 48, byte address width on both sides.
REQ-002 SHALL have parameter DataWidth, default 64, data width on both sides; strobe width is DataWidth/8.
REQ-003 SHALL have port clk_i  in  1  sole clock; all logic is rising-edge.
REQ-004 SHALL have port rst_ni  in  1  reset; asynchronous assert, active-low.
REQ-005 SHALL have port mem_req_i  in  1  memory-side request valid.
REQ-006 SHALL have port mem_gnt_o  out  1  request accepted this cycle.
REQ-007 SHALL have port mem_addr_i  in  AddrWidth  request byte address.
REQ-008 SHALL have port mem_we_i  in  1  1 = write, 0 = read.
REQ-009 SHALL have port mem_wdata_i  in  DataWidth  write data.
REQ-010 SHALL have port mem_strb_i  in  DataWidth/8  write byte enables.
REQ-011 SHALL have port mem_rvalid_o  out  1  one-cycle response pulse, reads and writes.
REQ-012 SHALL have port mem_rdata_o  out  DataWidth  read data; 0 for write responses.
REQ-013 SHALL have port mem_err_o  out  1  response error, valid with mem_rvalid_o.
REQ-014 SHALL have ports m_axi_awvalid out 1, m_axi_awready in 1, m_axi_awaddr out AddrWidth: AW channel.
REQ-015 SHALL have ports m_axi_wvalid out 1, m_axi_wready in 1, m_axi_wdata out DataWidth, m_axi_wstrb out DataWidth/8: W channel.
REQ-016 SHALL have ports m_axi_bvalid in 1, m_axi_bready out 1, m_axi_bresp in 2: B channel.
REQ-017 SHALL have ports m_axi_arvalid out 1, m_axi_arready in 1, m_axi_araddr out AddrWidth: AR channel.
REQ-018 SHALL have ports m_axi_rvalid in 1, m_axi_rready out 1, m_axi_rdata in DataWidth, m_axi_rresp in 2: R channel.
REQ-019 SHALL issue only single-beat transactions: ID 0, len 0, size log2(DataWidth/8), burst INCR, wlast 1; these constants are tied by the integrating wrapper, not ported.

Function
REQ-020 SHALL implement FSM states IDLE, WRITE, BWAIT, READ, RWAIT; exactly one transaction outstanding.
REQ-021 SHALL assert mem_gnt_o = mem_req_i in IDLE only, combinationally; 0 in all other states.
REQ-022 On grant SHALL register addr/wdata/strb and go to WRITE (we=1) or READ (we=0); AXI valids rise the next cycle, never combinationally from mem_req_i.
REQ-023 In WRITE SHALL assert awvalid and wvalid independently; each drops the cycle after its own handshake; AW-before-W, W-before-AW and simultaneous handshakes all legal; go to BWAIT once both are done.
REQ-024 In READ SHALL assert arvalid until arready, then go to RWAIT.
REQ-025 Valids and payloads SHALL stay stable until handshake (AXI rule).
REQ-026 bready SHALL be 1 only in BWAIT, rready only in RWAIT; a B/R beat arriving in any other state is a protocol error and is ignored.
REQ-027 On B handshake SHALL, next cycle, pulse mem_rvalid_o with mem_rdata_o=0, mem_err_o=bresp[1]; on R handshake likewise with mem_rdata_o=rdata, mem_err_o=rresp[1]; FSM returns to IDLE in the same cycle as the pulse.
REQ-028 mem_rdata_o and mem_err_o SHALL hold their last value between pulses.
REQ-029 A new request SHALL be grantable in the cycle mem_rvalid_o pulses; minimum turnaround is 3 cycles (read) / 3 cycles (write) with zero-wait slave.
REQ-030 EXOKAY (01) SHALL map to mem_err_o=0; SLVERR/DECERR to 1.

Reset
REQ-031 On rst_ni low SHALL immediately force IDLE and drive all valids, readies, mem_gnt_o, mem_rvalid_o, mem_err_o to 0 and mem_rdata_o, payload registers to 0, including mid-transaction; in-flight transactions are abandoned (system-reset use only).

Verification
REQ-032 Read 0x8000_0008, slave arready/rvalid immediate, rdata 0xDEAD_BEEF_0123_4567 -> arvalid cycle 1, mem_rvalid_o cycle 3 with that data, err 0.
REQ-033 Write 0x8000_0010, strb 0x0F, awready 3 cycles before wready -> awvalid drops alone, wvalid held, single B, mem_rvalid_o once, rdata 0.
REQ-034 Write with wready before awready, then simultaneous case -> one AW, one W, one response each.
REQ-035 Read with rresp=DECERR (11) -> mem_err_o=1 with pulse; following read rresp=OKAY -> mem_err_o=0.
REQ-036 mem_req_i held high continuously with back-to-back reads -> gnt only in IDLE, never two outstanding, no lost/duplicated responses.
REQ-037 rst_ni low during BWAIT -> all outputs 0 asynchronously; after release next request handled normally.
